// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch-type codes,
// the BTB training record layout and the redirect FSM states.
package branch_resolve_unit_pkg;

    localparam logic [1:0] COND = 2'b00;
    localparam logic [1:0] CALL = 2'b01;
    localparam logic [1:0] JUMP = 2'b10;
    localparam logic [1:0] RET  = 2'b11;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] target;
        logic [1:0]  br_type;
        logic        taken;
    } btb_update_t;

    typedef enum logic {
        IDLE,
        REDIR
    } bru_state_e;

    // A not-taken branch has no meaningful target, so only direction matters then.
    function automatic logic is_mispredict(
        input logic        taken,
        input logic        pred_taken,
        input logic [31:0] target,
        input logic [31:0] pred_target
    );
        return (taken != pred_taken) || (taken && (target != pred_target));
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Resolve, redirect and predictor-training signals of the branch resolve unit.
interface branch_resolve_unit_if;
    logic        flush_i;
    logic        res_valid_i;
    logic        res_ready_o;
    logic [29:0] res_pc_i;
    logic        res_taken_i;
    logic [1:0]  res_type_i;
    logic [31:0] res_target_i;
    logic        res_pred_taken_i;
    logic [31:0] res_pred_target_i;
    logic        redir_valid_o;
    logic        redir_ready_i;
    logic [31:0] redir_addr_o;
    logic        btb_valid_o;
    logic        btb_ready_i;
    logic [29:0] btb_pc_o;
    logic [31:0] btb_target_o;
    logic [1:0]  btb_type_o;
    logic        btb_taken_o;
    logic [31:0] mispredict_cnt_o;

    modport slave (
        input  flush_i, res_valid_i, res_pc_i, res_taken_i, res_type_i,
               res_target_i, res_pred_taken_i, res_pred_target_i,
               redir_ready_i, btb_ready_i,
        output res_ready_o, redir_valid_o, redir_addr_o, btb_valid_o,
               btb_pc_o, btb_target_o, btb_type_o, btb_taken_o, mispredict_cnt_o
    );

    modport master (
        output flush_i, res_valid_i, res_pc_i, res_taken_i, res_type_i,
               res_target_i, res_pred_taken_i, res_pred_target_i,
               redir_ready_i, btb_ready_i,
        input  res_ready_o, redir_valid_o, redir_addr_o, btb_valid_o,
               btb_pc_o, btb_target_o, btb_type_o, btb_taken_o, mispredict_cnt_o
    );
endinterface

// File: rtl/branch_resolve_unit_btb_update_fifo.sv
// Two-entry FIFO of BTB/RAS training records; head entry is read from registers.
module btb_update_fifo
    import branch_resolve_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  btb_update_t wdata,
    output btb_update_t rdata,
    output logic [1:0]  count
);

    btb_update_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        push_en;
    logic        pop_en;

    assign push_en = push && (count != 2'd2);
    assign pop_en  = pop && (count != 2'd0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_en) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch outcomes against predictions, issues fetch redirects on
// mispredicts, queues predictor training records and counts mispredicts.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
(
    input logic                  cpu_clk_i,
    input logic                  cpu_rst_ni,
    branch_resolve_unit_if.slave bus
);

    bru_state_e  state_q;
    bru_state_e  state_d;
    logic [31:0] redir_addr_q;
    logic [31:0] mis_cnt_q;
    logic [1:0]  fifo_count;
    btb_update_t fifo_wdata;
    btb_update_t fifo_rdata;
    logic        accept;
    logic        mispredict;
    logic        push;
    logic        pop;

    // Gating with reset keeps the upstream stage from seeing a hand-shake during reset.
    assign bus.res_ready_o = cpu_rst_ni && (state_q == IDLE) &&
                             (fifo_count != 2'd2) && !bus.flush_i;

    assign mispredict = is_mispredict(bus.res_taken_i, bus.res_pred_taken_i,
                                      bus.res_target_i, bus.res_pred_target_i);
    assign accept     = bus.res_valid_i && bus.res_ready_o;
    assign push       = accept && (bus.res_taken_i || mispredict);
    assign pop        = bus.btb_valid_o && bus.btb_ready_i;

    assign fifo_wdata = '{pc:      bus.res_pc_i,
                          target:  bus.res_target_i,
                          br_type: bus.res_type_i,
                          taken:   bus.res_taken_i};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && mispredict) state_d = REDIR;
            REDIR:   if (bus.flush_i || bus.redir_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            state_q      <= IDLE;
            redir_addr_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept && mispredict) begin
                redir_addr_q <= bus.res_target_i;
                mis_cnt_q    <= mis_cnt_q + 32'd1;
            end
        end
    end

    btb_update_fifo u_fifo (
        .clk   (cpu_clk_i),
        .rst_n (cpu_rst_ni),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign bus.redir_valid_o    = (state_q == REDIR);
    assign bus.redir_addr_o     = redir_addr_q;
    assign bus.btb_valid_o      = (fifo_count != 2'd0);
    assign bus.btb_pc_o         = fifo_rdata.pc;
    assign bus.btb_target_o     = fifo_rdata.target;
    assign bus.btb_type_o       = fifo_rdata.br_type;
    assign bus.btb_taken_o      = fifo_rdata.taken;
    assign bus.mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed table, corner sequences
// and random traffic against a queue-based reference model.
module tb_branch_resolve_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_resolve_unit_if bif ();

    branch_resolve_unit dut (
        .cpu_clk_i  (clk),
        .cpu_rst_ni (rst_n),
        .bus        (bif)
    );

    typedef struct {
        logic [29:0] pc;
        logic [31:0] target;
        logic [1:0]  kind;
        logic        taken;
    } rec_t;

    typedef struct {
        logic [1:0]  kind;
        logic        taken;
        logic [31:0] target;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        exp_redir;
        logic        exp_push;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    rec_t        m_q[$];
    bit          m_redir;
    logic [31:0] m_addr;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bif.flush_i           = 1'b0;
        bif.res_valid_i       = 1'b0;
        bif.res_pc_i          = '0;
        bif.res_taken_i       = 1'b0;
        bif.res_type_i        = 2'b00;
        bif.res_target_i      = '0;
        bif.res_pred_taken_i  = 1'b0;
        bif.res_pred_target_i = '0;
        bif.redir_ready_i     = 1'b0;
        bif.btb_ready_i       = 1'b0;
    endtask

    task automatic offer(input logic [29:0] pc, input logic [1:0] kind, input logic taken,
                         input logic [31:0] target, input logic pred_taken,
                         input logic [31:0] pred_target);
        bif.res_valid_i       = 1'b1;
        bif.res_pc_i          = pc;
        bif.res_type_i        = kind;
        bif.res_taken_i       = taken;
        bif.res_target_i      = target;
        bif.res_pred_taken_i  = pred_taken;
        bif.res_pred_target_i = pred_target;
    endtask

    task automatic check_outputs();
        chk("redir_valid", bif.redir_valid_o, m_redir);
        chk("redir_addr", bif.redir_addr_o, m_addr);
        chk("btb_valid", bif.btb_valid_o, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("btb_pc", bif.btb_pc_o, m_q[0].pc);
            chk("btb_target", bif.btb_target_o, m_q[0].target);
            chk("btb_type", bif.btb_type_o, m_q[0].kind);
            chk("btb_taken", bif.btb_taken_o, m_q[0].taken);
        end
        chk("mispredict_cnt", bif.mispredict_cnt_o, m_cnt);
    endtask

    // Called at posedge+1 with inputs applied; advances model and DUT by one clock.
    task automatic cycle();
        bit acc;
        bit mis;
        bit exp_ready;
        #1;
        exp_ready = !m_redir && (m_q.size() < 2) && !bif.flush_i;
        chk("res_ready", bif.res_ready_o, exp_ready);
        acc = bif.res_valid_i && exp_ready;
        mis = (bif.res_taken_i != bif.res_pred_taken_i) ||
              (bif.res_taken_i && (bif.res_target_i != bif.res_pred_target_i));
        if (m_q.size() != 0 && bif.btb_ready_i) m_q.delete(0);
        if (acc && (bif.res_taken_i || mis))
            m_q.push_back('{pc: bif.res_pc_i, target: bif.res_target_i,
                            kind: bif.res_type_i, taken: bif.res_taken_i});
        if (m_redir) begin
            if (bif.flush_i || bif.redir_ready_i) m_redir = 1'b0;
        end else if (acc && mis) begin
            m_redir = 1'b1;
            m_addr  = bif.res_target_i;
        end
        if (acc && mis) m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        m_q.delete();
        m_redir = 1'b0;
        m_addr  = '0;
        m_cnt   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", bif.res_ready_o, 1'b0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        bif.redir_ready_i = 1'b1;
        bif.btb_ready_i   = 1'b1;
        repeat (3) cycle();
        idle_inputs();
    endtask

    vec_t vecs[8];

    initial begin
        // kind, taken, target, pred_taken, pred_target, exp_redir, exp_push
        vecs[0] = '{2'b00, 1'b0, 32'h0000_0104, 1'b0, 32'h0000_0104, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_0104, 1'b1, 1'b1};
        vecs[2] = '{2'b00, 1'b0, 32'h0000_0104, 1'b1, 32'h0000_3000, 1'b1, 1'b1};
        vecs[3] = '{2'b00, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3000, 1'b0, 1'b1};
        vecs[4] = '{2'b01, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0504, 1'b1, 1'b1};
        vecs[5] = '{2'b10, 1'b1, 32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b1};
        vecs[6] = '{2'b11, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080, 1'b1, 1'b1};
        vecs[7] = '{2'b00, 1'b0, 32'h0000_0104, 1'b0, 32'h0000_9999, 1'b0, 1'b0};

        do_reset();

        foreach (vecs[i]) begin
            offer(30'h40 + 30'(i), vecs[i].kind, vecs[i].taken, vecs[i].target,
                  vecs[i].pred_taken, vecs[i].pred_target);
            cycle();
            chk($sformatf("tbl%0d_redir", i), bif.redir_valid_o, vecs[i].exp_redir);
            chk($sformatf("tbl%0d_push", i), bif.btb_valid_o, vecs[i].exp_push);
            drain();
        end
        chk("tbl_mispredicts", bif.mispredict_cnt_o, 32'd4);

        // Redirect held while fetch stalls
        offer(30'h80, 2'b11, 1'b1, 32'h40, 1'b1, 32'h80);
        cycle();
        idle_inputs();
        bif.res_valid_i = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            chk("held_valid", bif.redir_valid_o, 1'b1);
            chk("held_addr", bif.redir_addr_o, 32'h40);
            bif.redir_ready_i = (k == 3);
            cycle();
        end
        chk("held_released", bif.redir_valid_o, 1'b0);
        drain();

        // FIFO full back-pressure
        offer(30'h100, 2'b10, 1'b1, 32'h1000, 1'b1, 32'h1000);
        cycle();
        offer(30'h101, 2'b10, 1'b1, 32'h1100, 1'b1, 32'h1100);
        cycle();
        offer(30'h102, 2'b10, 1'b1, 32'h1200, 1'b1, 32'h1200);
        #1;
        chk("full_ready", bif.res_ready_o, 1'b0);
        bif.btb_ready_i = 1'b1;
        cycle();
        bif.btb_ready_i = 1'b0;
        #1;
        chk("resume_ready", bif.res_ready_o, 1'b1);
        cycle();
        chk("resume_tail_pc", bif.btb_pc_o, 30'h101);
        drain();

        // Flush while redirecting
        offer(30'h200, 2'b00, 1'b1, 32'h2200, 1'b0, 32'h0804);
        cycle();
        idle_inputs();
        bif.flush_i = 1'b1;
        cycle();
        bif.flush_i = 1'b0;
        chk("flush_redir", bif.redir_valid_o, 1'b0);
        chk("flush_fifo", bif.btb_valid_o, 1'b1);
        chk("flush_cnt", bif.mispredict_cnt_o, 32'd6);
        drain();

        // Counter wrap
        force dut.mis_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mis_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("wrap_preload", bif.mispredict_cnt_o, 32'hFFFF_FFFF);
        offer(30'h300, 2'b01, 1'b1, 32'h3000, 1'b0, 32'h0);
        cycle();
        chk("wrap_zero", bif.mispredict_cnt_o, 32'd0);
        idle_inputs();
        cycle();

        // Asynchronous reset while redirecting with FIFO occupied
        chk("pre_rst_redir", bif.redir_valid_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", bif.res_ready_o, 1'b0);
        chk("arst_redir", bif.redir_valid_o, 1'b0);
        chk("arst_addr", bif.redir_addr_o, 32'd0);
        chk("arst_btb_valid", bif.btb_valid_o, 1'b0);
        chk("arst_btb_data", {bif.btb_pc_o, bif.btb_target_o, bif.btb_type_o, bif.btb_taken_o}, 64'd0);
        chk("arst_cnt", bif.mispredict_cnt_o, 32'd0);
        do_reset();

        // Random traffic
        for (int unsigned n = 0; n < 400; n++) begin
            logic [1:0]  kind;
            logic        taken;
            logic [31:0] target;
            kind   = 2'($urandom_range(0, 3));
            taken  = (kind == 2'b00) ? 1'($urandom_range(0, 1)) : 1'b1;
            target = {$urandom_range(0, 15) == 0 ? 28'($urandom) : 28'h0000_010, 4'h0};
            bif.res_valid_i       = ($urandom_range(0, 3) != 0);
            bif.res_pc_i          = 30'($urandom);
            bif.res_type_i        = kind;
            bif.res_taken_i       = taken;
            bif.res_target_i      = target;
            bif.res_pred_taken_i  = ($urandom_range(0, 3) == 0) ? ~taken : taken;
            bif.res_pred_target_i = ($urandom_range(0, 3) == 0) ? target ^ 32'h10 : target;
            bif.redir_ready_i     = ($urandom_range(0, 2) == 0);
            bif.btb_ready_i       = ($urandom_range(0, 1) == 0);
            bif.flush_i           = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Sits between the branch execution unit and the frontend. It accepts one resolved branch per cycle over a valid/ready handshake and compares the actual outcome with the prediction carried down the pipe. On a mispredict it raises a registered redirect to the fetch unit and holds it until accepted. It also queues BTB/RAS training records in a 2-entry FIFO that drains to the predictor update port, and counts mispredicts.

## Interface
- No parameters. Record widths are fixed: PC 30 bits (word address), target 32 bits.
- cpu_clk_i  in  1  core clock
- cpu_rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush from commit; aborts a pending redirect
- res_valid_i  in  1  resolved branch present
- res_ready_o  out  1  record accepted this cycle when high with res_valid_i
- res_pc_i  in  30  branch PC[31:2]
- res_taken_i  in  1  actual direction (always 1 for jal/jalr)
- res_type_i  in  2  00 cond, 01 call, 10 jump, 11 ret
- res_target_i  in  32  actual next PC (taken target, or PC+4 when not taken)
- res_pred_taken_i  in  1  predicted direction
- res_pred_target_i  in  32  predicted next PC
- redir_valid_o  out  1  redirect request to fetch
- redir_ready_i  in  1  fetch accepts redirect
- redir_addr_o  out  32  restart address
- btb_valid_o  out  1  training record available
- btb_ready_i  in  1  predictor consumes record
- btb_pc_o  out  30; btb_target_o  out  32; btb_type_o  out  2; btb_taken_o  out  1  head-of-FIFO record
- mispredict_cnt_o  out  32  free-running mispredict count

## Operation
- Mispredict = (res_taken_i != res_pred_taken_i) OR (res_taken_i AND res_target_i != res_pred_target_i).
- Accept = res_valid_i && res_ready_o.
- res_ready_o = (state == IDLE) && (fifo count < 2) && !flush_i. A same-cycle FIFO pop does not free a slot for acceptance.
- FSM has two states: IDLE and REDIR.
  - IDLE → REDIR on an accepted mispredict; redir_addr_o is registered from res_target_i.
  - REDIR → IDLE when redir_ready_i or flush_i is high.
  - redir_valid_o = (state == REDIR). redir_addr_o is stable while it is high.
- BTB push on accept when res_taken_i OR mispredict. Correctly predicted not-taken branches are not pushed.
- The FIFO holds {pc, target, type, taken}.
  - Pop when btb_valid_o && btb_ready_i.
  - Push and pop may occur in the same cycle; count is unchanged.
  - btb_valid_o = (count != 0).
  - flush_i does not clear the FIFO, because training data stays valid.
- mispredict_cnt_o increments by 1 on every accepted mispredict and wraps at 2^32−1 → 0. It is unaffected by flush_i.
- flush_i has priority over redir_ready_i. The cycle after a flush, state is IDLE and redir_valid_o is 0.

## Timing
- Reset values:
  - state IDLE, count 0, FIFO pointers 0.
  - redir_valid_o 0, redir_addr_o 0, btb_valid_o 0, btb_* data 0, mispredict_cnt_o 0.
  - res_ready_o 0 while reset is asserted.
- Redirect latency: a mispredict accepted at edge N gives redir_valid_o high in cycle N+1.
- BTB latency: a record pushed at edge N is visible on btb_* in cycle N+1 if the FIFO was empty.
- All outputs are registered except res_ready_o, which is combinational from state, count and flush_i.
- Reset asserted mid-redirect or mid-drain: all state clears immediately (asynchronous). Release is synchronous to cpu_clk_i.

## Structure
- Shared package holds:
  - the branch-type encoding constants (COND=2'b00, CALL=2'b01, JUMP=2'b10, RET=2'b11), shared with the execution branch unit;
  - the packed btb_update_t struct {pc[29:0], target[31:0], type[1:0], taken}.
- One sub-module, btb_update_fifo: a 2-entry synchronous FIFO of btb_update_t with push/pop/count.

## Test plan
- Correct predict: cond, pc=0x100>>2, taken=0, pred_taken=0 → no redirect, no BTB push, count stays 0.
- Direction mispredict: cond, taken=1, target=0x2000, pred_taken=0 → redir_valid_o=1 next cycle with addr 0x2000; BTB record taken=1; mispredict_cnt_o=1.
- Target mispredict held: ret, target=0x40, pred_target=0x80, redir_ready_i low for 3 cycles → redir_valid_o and addr 0x40 stable for 4 cycles; res_ready_o=0 throughout.
- FIFO full: btb_ready_i=0, two taken jumps accepted → res_ready_o=0 on the third offer; raising btb_ready_i pops one record, and acceptance resumes the following cycle.
- Flush during REDIR: flush_i pulsed while redir_valid_o=1 → redir_valid_o=0 next cycle; FIFO count and mispredict_cnt_o unchanged.
- Counter wrap and reset: preload count to 0xFFFFFFFF by forcing, then one mispredict → 0. Asserting cpu_rst_ni low mid-REDIR → all outputs reach reset values without waiting for a clock edge.
